// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions used by the arbiter, the ROB and the reservation stations.
package cdb_pkg;

    localparam int CDB_TAG_W  = 3;
    localparam int CDB_DATA_W = 32;

    localparam int TAG_NONE = 0;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_BR  = 2'd2
    } cdb_src_e;

    // Next round-robin start point: one past the winner, wrapping after the last source.
    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int numSrc);
        if (int'(idx) >= numSrc - 1) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Execution-unit result bus and broadcast CDB; the arbiter is the slave side.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
);

    logic                      flush;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_value;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_value;
    logic [1:0]                cdb_src;

    modport master (
        output flush,
        output src_valid,
        output src_tag,
        output src_value,
        input  src_ready,
        input  cdb_valid,
        input  cdb_tag,
        input  cdb_value,
        input  cdb_src
    );

    modport slave (
        input  flush,
        input  src_valid,
        input  src_tag,
        input  src_value,
        output src_ready,
        output cdb_valid,
        output cdb_tag,
        output cdb_value,
        output cdb_src
    );

endinterface

// File: rtl/cdb_src_fifo.sv
// Small per-source result FIFO holding (tag, value) pairs until the CDB grants them.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [DATA_W-1:0] i_value,
    output logic              o_empty,
    output logic              o_full,
    output logic [TAG_W-1:0]  o_headTag,
    output logic [DATA_W-1:0] o_headValue
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [TAG_W+DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wrPtr;
    logic [PTR_W-1:0]        r_rdPtr;
    logic [PTR_W:0]          r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_FULL);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    assign {o_headTag, o_headValue} = r_mem[r_rdPtr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= {i_tag, i_value};
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single ROB write-back port (the CDB) between execution units.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int DEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    localparam logic [TAG_W-1:0] W_TAG_NONE = TAG_W'(TAG_NONE);

    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic [TAG_W-1:0]   w_headTag   [NUM_SRC];
    logic [DATA_W-1:0]  w_headValue [NUM_SRC];

    logic              w_grantValid;
    logic [1:0]        w_grantIdx;
    logic [TAG_W-1:0]  w_grantTag;
    logic [DATA_W-1:0] w_grantValue;

    logic [1:0]        r_rrPtr;
    logic              r_cdbValid;
    logic [TAG_W-1:0]  r_cdbTag;
    logic [DATA_W-1:0] r_cdbValue;
    logic [1:0]        r_cdbSrc;

    // Ready comes straight from registered fullness, never from this cycle's pop.
    assign bus.src_ready = ~w_full;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign w_push[i] = bus.src_valid[i] && !w_full[i] && !bus.flush
                           && (bus.src_tag[i*TAG_W +: TAG_W] != W_TAG_NONE);
        assign w_pop[i]  = w_grantValid && (w_grantIdx == 2'(i));

        cdb_src_fifo #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .i_push      (w_push[i]),
            .i_pop       (w_pop[i]),
            .i_flush     (bus.flush),
            .i_tag       (bus.src_tag[i*TAG_W +: TAG_W]),
            .i_value     (bus.src_value[i*DATA_W +: DATA_W]),
            .o_empty     (w_empty[i]),
            .o_full      (w_full[i]),
            .o_headTag   (w_headTag[i]),
            .o_headValue (w_headValue[i])
        );
    end

    // First non-empty FIFO at or after the round-robin pointer wins.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = 2'd0;
        w_grantTag   = '0;
        w_grantValue = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            int idx;
            idx = (int'(r_rrPtr) + off) % NUM_SRC;
            if (!w_grantValid && !w_empty[idx]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = 2'(idx);
                w_grantTag   = w_headTag[idx];
                w_grantValue = w_headValue[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rrPtr    <= 2'd0;
            r_cdbValid <= 1'b0;
            r_cdbTag   <= '0;
            r_cdbValue <= '0;
            r_cdbSrc   <= 2'd0;
        end else if (bus.flush) begin
            r_rrPtr    <= 2'd0;
            r_cdbValid <= 1'b0;
            r_cdbTag   <= '0;
            r_cdbValue <= '0;
        end else if (w_grantValid) begin
            r_rrPtr    <= rr_next(w_grantIdx, NUM_SRC);
            r_cdbValid <= 1'b1;
            r_cdbTag   <= w_grantTag;
            r_cdbValue <= w_grantValue;
            r_cdbSrc   <= w_grantIdx;
        end else begin
            r_cdbValid <= 1'b0;
            r_cdbTag   <= '0;
            r_cdbValue <= '0;
        end
    end

    assign bus.cdb_valid = r_cdbValid;
    assign bus.cdb_tag   = r_cdbTag;
    assign bus.cdb_value = r_cdbValue;
    assign bus.cdb_src   = r_cdbSrc;

endmodule
